// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encodings, flag bit positions
// and the segment-width helper used to split the adder across stages.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101
  } alu_op_e;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/cla_segment.sv
// SEG-bit carry-lookahead adder built from 4-bit lookahead groups; groups are
// chained, so each bit's carry is a flat sum-of-products from its group carry-in.
module cla_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  output logic [SEG-1:0] o_sum,
  output logic           o_c,
  output logic           o_c_msb
);

  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    localparam int BASE = (i / 4) * 4;
    logic       w_ci;
    logic       w_co;
    logic [4:0] w_t;

    if (i == 0) begin : g_first
      assign w_ci = i_c;
    end else begin : g_chain
      assign w_ci = g_bit[i-1].w_co;
    end

    // Term d: generate at bit i-d propagated through bits i..i-d+1.
    for (genvar d = 0; d < 4; d++) begin : g_term
      if (d == 0) begin : g_gen
        assign w_t[d] = w_g[i];
      end else if (i - d >= BASE) begin : g_prop
        assign w_t[d] = w_g[i-d] & (&w_p[i -: d]);
      end else begin : g_none
        assign w_t[d] = 1'b0;
      end
    end

    assign w_t[4]   = (&w_p[i:BASE]) & g_bit[BASE].w_ci;
    assign w_co     = |w_t;
    assign o_sum[i] = w_p[i] ^ w_ci;
  end

  assign o_c     = g_bit[SEG-1].w_co;
  assign o_c_msb = g_bit[SEG-1].w_ci;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with NZCV flags: the add is split into STAGES lookahead
// segments with the carry registered between them; the whole pipe stalls together.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       nzcv
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  logic             w_adv;
  logic [WIDTH-1:0] w_ai;
  logic [WIDTH-1:0] w_bi;
  logic [WIDTH-1:0] w_logic;

  assign w_ai     = FS[0] ? ~A : A;
  assign w_bi     = FS[1] ? ~B : B;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Shifts use the raw B as the amount; ADD starts from zero and is filled per segment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_logic = '0;
    case (FS[4:2])
      OP_AND:  w_logic = w_ai & w_bi;
      OP_OR:   w_logic = w_ai | w_bi;
      OP_XOR:  w_logic = w_ai ^ w_bi;
      OP_SHL:  w_logic = w_ai << B[SHW-1:0];
      OP_SHR:  w_logic = w_ai >> B[SHW-1:0];
      default: w_logic = '0;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM = WIDTH - k * SEG;
    logic             w_v;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_res;
    logic [REM-1:0]   w_a;
    logic [REM-1:0]   w_b;
    logic             w_c;
    logic [SEG-1:0]   w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_res_nxt;

    if (k == 0) begin : g_src0
      assign w_v   = in_valid;
      assign w_op  = FS[4:2];
      assign w_res = w_logic;
      assign w_a   = w_ai;
      assign w_b   = w_bi;
      assign w_c   = C_in;
    end else begin : g_srcn
      assign w_v   = g_stage[k-1].g_fwd.r_valid;
      assign w_op  = g_stage[k-1].g_fwd.r_op;
      assign w_res = g_stage[k-1].g_fwd.r_res;
      assign w_a   = g_stage[k-1].g_fwd.r_a;
      assign w_b   = g_stage[k-1].g_fwd.r_b;
      assign w_c   = g_stage[k-1].g_fwd.r_c;
    end

    always_comb begin
      w_res_nxt = w_res;
      if (w_op == OP_ADD) w_res_nxt[k*SEG +: SEG] = w_sum;
    end

    if (k < STAGES - 1) begin : g_fwd
      logic                 w_msb_carry_unused;
      logic                 r_valid;
      logic [2:0]           r_op;
      logic [WIDTH-1:0]     r_res;
      logic [REM-SEG-1:0]   r_a;
      logic [REM-SEG-1:0]   r_b;
      logic                 r_c;

      cla_segment #(.SEG(SEG)) u_cla (
        .i_a(w_a[SEG-1:0]), .i_b(w_b[SEG-1:0]), .i_c(w_c),
        .o_sum(w_sum), .o_c(w_co), .o_c_msb(w_msb_carry_unused)
      );

      always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (reset)      r_valid <= 1'b0;
        else if (w_adv) r_valid <= w_v;
      end

      // NOTE: datapath registers carry no reset; the valid bits alone decide what is meaningful.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_op  <= w_op;
          r_res <= w_res_nxt;
          r_a   <= w_a[REM-1:SEG];
          r_b   <= w_b[REM-1:SEG];
          r_c   <= w_co;
        end
      end
    end else begin : g_last
      logic             w_cmsb;
      logic [3:0]       w_flags;
      logic             r_valid;
      logic [WIDTH-1:0] r_res;
      logic [3:0]       r_nzcv;

      cla_segment #(.SEG(SEG)) u_cla (
        .i_a(w_a[SEG-1:0]), .i_b(w_b[SEG-1:0]), .i_c(w_c),
        .o_sum(w_sum), .o_c(w_co), .o_c_msb(w_cmsb)
      );

      // Signed overflow is the carry into the MSB differing from the carry out.
      always_comb begin
        w_flags         = '0;
        w_flags[NZCV_N] = w_res_nxt[WIDTH-1];
        w_flags[NZCV_Z] = ~|w_res_nxt;
        if (w_op == OP_ADD) begin
          w_flags[NZCV_C] = w_co;
          w_flags[NZCV_V] = w_co ^ w_cmsb;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid <= 1'b0;
          r_res   <= '0;
          r_nzcv  <= '0;
        end else if (w_adv) begin
          r_valid <= w_v;
          r_res   <= w_res_nxt;
          r_nzcv  <= w_flags;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].g_last.r_valid;
  assign F         = g_stage[STAGES-1].g_last.r_res;
  assign nzcv      = g_stage[STAGES-1].g_last.r_nzcv;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=64, STAGES=4): directed vectors,
// random beats against a plain-arithmetic reference, backpressure and mid-flight reset.
module tb_alu_pipe;

  localparam int W  = 64;
  localparam int ST = 4;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [4:0]    FS;
  logic          C_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  F;
  logic [3:0]    nzcv;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .C_in(C_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .nzcv(nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: returns {F, N, Z, C, V}.
  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [4:0] fs, input logic cin);
    logic [63:0] ai, bi, f;
    logic [64:0] wide;
    logic c, v;
    ai = fs[0] ? ~a : a;
    bi = fs[1] ? ~b : b;
    c = 1'b0;
    v = 1'b0;
    case (fs[4:2])
      3'd0: f = ai & bi;
      3'd1: f = ai | bi;
      3'd2: begin
        wide = {1'b0, ai} + {1'b0, bi} + {64'd0, cin};
        f = wide[63:0];
        c = wide[64];
        v = (ai[63] == bi[63]) && (f[63] != ai[63]);
      end
      3'd3: f = ai ^ bi;
      3'd4: f = ai << b[5:0];
      3'd5: f = ai >> b[5:0];
      default: f = 64'd0;
    endcase
    return {f, f[63], (f == 64'd0), c, v};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Sends one beat into an idle pipe and waits (bounded) for its result.
  task automatic do_beat(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs,
                         input logic cin, output logic [63:0] f, output logic [3:0] flags,
                         output int lat);
    @(negedge clk);
    A = a; B = b; FS = fs; C_in = cin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    f = F;
    flags = nzcv;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; FS = '0; C_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (F !== 64'd0) begin bad++; $display("FAIL reset_F: got %h want 0", F); end
    total++; if (nzcv !== 4'd0) begin bad++; $display("FAIL reset_nzcv: got %b want 0000", nzcv); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic [63:0] f; logic [3:0] n; int lat;
    do_beat(64'd196, 64'd562, 5'b01000, 1'b0, f, n, lat);
    total++; if (f !== 64'd758) begin bad++; $display("FAIL add_F: got %h want %h", f, 64'd758); end
    total++; if (n !== 4'b0000) begin bad++; $display("FAIL add_nzcv: got %b want 0000", n); end
    total++; if (lat != ST) begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, ST); end
  endtask

  task automatic test_sub();
    logic [63:0] f; logic [3:0] n; int lat;
    do_beat(64'd5, 64'd7, 5'b01010, 1'b1, f, n, lat);
    total++; if (f !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL sub_neg_F: got %h want fffffffffffffffe", f); end
    total++; if (n !== 4'b1000) begin bad++; $display("FAIL sub_neg_nzcv: got %b want 1000", n); end
    do_beat(64'd7, 64'd5, 5'b01010, 1'b1, f, n, lat);
    total++; if (f !== 64'd2) begin bad++; $display("FAIL sub_pos_F: got %h want 2", f); end
    total++; if (n !== 4'b0010) begin bad++; $display("FAIL sub_pos_nzcv: got %b want 0010", n); end
  endtask

  task automatic test_carry_overflow();
    logic [63:0] f; logic [3:0] n; int lat;
    do_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, f, n, lat);
    total++; if (f !== 64'd0) begin bad++; $display("FAIL carry_F: got %h want 0", f); end
    total++; if (n !== 4'b0110) begin bad++; $display("FAIL carry_nzcv: got %b want 0110", n); end
    do_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, f, n, lat);
    total++; if (f !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_F: got %h want 8000000000000000", f); end
    total++; if (n !== 4'b1001) begin bad++; $display("FAIL ovf_nzcv: got %b want 1001", n); end
  endtask

  task automatic test_logic_shift();
    logic [63:0] ta[6], tb[6], tf[6];
    logic [4:0]  tfs[6];
    logic [3:0]  tn[6];
    logic [63:0] f; logic [3:0] n; int lat;
    ta  = '{64'hF0, 64'hF0, 64'hF0, 64'd1, 64'd1, 64'hF0};
    tb  = '{64'h3C, 64'h3C, 64'h3C, 64'd63, 64'd63, 64'h3C};
    tfs = '{5'b00000, 5'b00100, 5'b01100, 5'b10000, 5'b10100, 5'b11000};
    tf  = '{64'h30, 64'hFC, 64'hCC, 64'h8000_0000_0000_0000, 64'd0, 64'd0};
    tn  = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      do_beat(ta[i], tb[i], tfs[i], 1'b0, f, n, lat);
      total++; if (f !== tf[i]) begin bad++; $display("FAIL logic_F[%0d]: got %h want %h", i, f, tf[i]); end
      total++; if (n !== tn[i]) begin bad++; $display("FAIL logic_nzcv[%0d]: got %b want %b", i, n, tn[i]); end
    end
  endtask

  task automatic test_random_ops();
    logic [63:0] a, b, f; logic [4:0] fs; logic cin; logic [3:0] n; logic [67:0] e; int lat;
    for (int i = 0; i < 12; i++) begin
      a = rand64(); b = rand64(); fs = 5'($urandom_range(0, 31)); cin = 1'($urandom_range(0, 1));
      e = ref_alu(a, b, fs, cin);
      do_beat(a, b, fs, cin, f, n, lat);
      total++;
      if ({f, n} !== e) begin
        bad++;
        $display("FAIL random[%0d] fs=%b: got F=%h nzcv=%b want F=%h nzcv=%b", i, fs, f, n, e[67:4], e[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ba[8], bb[8];
    logic [4:0]  bf[8];
    logic        bc[8];
    logic [67:0] expq[$];
    logic [67:0] e;
    logic [63:0] held_f;
    logic [3:0]  held_n;
    bit          have_held;
    int          idx, got, seen;
    for (int i = 0; i < 8; i++) begin
      ba[i] = rand64(); bb[i] = rand64();
      bf[i] = 5'($urandom_range(0, 31)); bc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0; have_held = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 7);
      if (idx < 8) begin
        in_valid = 1'b1; A = ba[idx]; B = bb[idx]; FS = bf[idx]; C_in = bc[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c <= 7 && out_valid) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, in_ready); end
        if (have_held) begin
          total++;
          if (F !== held_f || nzcv !== held_n) begin
            bad++; $display("FAIL stall_hold c=%0d: got F=%h nzcv=%b want F=%h nzcv=%b", c, F, nzcv, held_f, held_n);
          end
        end
        held_f = F; held_n = nzcv; have_held = 1;
      end
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL stream_extra: got F=%h with no beat outstanding, want none", F);
        end else begin
          e = expq.pop_front();
          if ({F, nzcv} !== e) begin
            bad++; $display("FAIL stream[%0d]: got F=%h nzcv=%b want F=%h nzcv=%b", got, F, nzcv, e[67:4], e[3:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_alu(ba[idx], bb[idx], bf[idx], bc[idx]));
        idx++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != 8 || expq.size() != 0 || !have_held) begin
      bad++; $display("FAIL stream_count: got %0d results (%0d pending, stall seen %0d) want 8 (0 pending, stall seen 1)", got, expq.size(), have_held);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL stream_dup: got %0d extra valid cycles want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] a, b, f; logic [4:0] fs; logic cin; logic [3:0] n; logic [67:0] e; int lat, seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A = rand64(); B = rand64(); FS = 5'b01000; C_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    total++; if (F !== 64'd0) begin bad++; $display("FAIL rstmid_F: got %h want 0", F); end
    total++; if (nzcv !== 4'd0) begin bad++; $display("FAIL rstmid_nzcv: got %b want 0000", nzcv); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_flushed: got %0d valid cycles want 0", seen); end
    a = rand64(); b = rand64(); fs = 5'b01010; cin = 1'b1;
    e = ref_alu(a, b, fs, cin);
    do_beat(a, b, fs, cin, f, n, lat);
    total++;
    if ({f, n} !== e) begin
      bad++; $display("FAIL rstmid_new: got F=%h nzcv=%b want F=%h nzcv=%b", f, n, e[67:4], e[3:0]);
    end
    total++; if (lat != ST) begin bad++; $display("FAIL rstmid_latency: got %0d want %0d", lat, ST); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry_overflow();
    test_logic_shift();
    test_random_ops();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
